max11046_burst_reader: RTL and testbench

- Parametrised successor to the single-word MAX11046 parallel-to-serial shifter.
- Drives the complete conversion cycle of a multi-channel MAX11046-class ADC: CONVST pulse, wait for EOC, N_CH sequential CS/RD reads of the parallel bus into a channel buffer, then serialises the whole frame MSB-first on a divided serial clock with a frame strobe.
- Sits between the ADC pins and the force-measurement serial link / downstream logic.
- Runs entirely in the single system clock domain. EOC is synchronised internally.

---
 rtl/max11046_pkg.sv | 24 ++
 rtl/max11046_burst_reader_serializer.sv | 61 ++++++
 rtl/max11046_burst_reader.sv | 140 ++++++++++++++
 tb/tb_max11046_burst_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/max11046_pkg.sv
// max11046_pkg: shared FSM states and frame sizing rules for the MAX11046 burst reader.
// Optional feature macro MAX11046_CH_TAG_EN: prefix every channel word with its channel index.
package max11046_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT_EOC,
    S_RD_LOW,
    S_RD_HIGH,
    S_SHIFT,
    S_DONE
  } state_e;
`ifdef MAX11046_CH_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  function automatic int tag_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction
  function automatic int frame_len(input int data_w, input int n_ch, input bit tag_en);
    return n_ch * (data_w + (tag_en ? tag_w(n_ch) : 0));
  endfunction
endpackage

// File: rtl/max11046_burst_reader_serializer.sv
// adc_frame_serializer: shifts a loaded frame out MSB first on a divided serial clock.
// Ports: clk, rst_n (async active-low); load_i latches frame_i and starts the frame;
// ser_clk_o / ser_data_o / ser_frame_o drive the link; last_o pulses once the
// falling ser_clk edge after the final bit has been issued.
module adc_frame_serializer #(
  parameter int FL      = 128,
  parameter int SER_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [FL-1:0] frame_i,
  output logic          ser_clk_o,
  output logic          ser_data_o,
  output logic          ser_frame_o,
  output logic          last_o
);
  localparam int DIV_W = (SER_DIV > 1) ? $clog2(SER_DIV) : 1;
  localparam int BIT_W = $clog2(FL + 1);
  logic [FL-1:0]    sr_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bits_q;
  logic             sclk_q, frame_q, last_q;
  logic             div_end;
  assign div_end = div_q == DIV_W'(SER_DIV - 1);
  // bits_q counts rising edges; data only advances when ser_clk falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      sclk_q  <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      sr_q    <= frame_i;
      div_q   <= '0;
      bits_q  <= '0;
      sclk_q  <= 1'b0;
      frame_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      last_q <= 1'b0;
      if (frame_q) begin
        div_q <= div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sclk_q <= ~sclk_q;
          if (!sclk_q) bits_q <= bits_q + 1'b1;
          else if (bits_q == BIT_W'(FL)) begin
            frame_q <= 1'b0;
            last_q  <= 1'b1;
          end else sr_q <= sr_q << 1;
        end
      end
    end
  end
  assign ser_clk_o   = sclk_q;
  assign ser_data_o  = frame_q & sr_q[FL-1];
  assign ser_frame_o = frame_q;
  assign last_o      = last_q;
endmodule

// File: rtl/max11046_burst_reader.sv
// max11046_burst_reader: runs CONVST, EOC wait, N_CH CS/RD reads and serialises the frame.
// Ports: clock, reset_n (async active-low); start requests one cycle; eoc_n/db_in from ADC;
// convst_n/cs_n/rd_n ADC strobes; ser_clk/ser_data/ser_frame serial link;
// busy, done pulse, sticky overrun and timeout flags.
// Macro MAX11046_CH_TAG_EN inserts a channel-index tag ahead of each word.
module max11046_burst_reader
  import max11046_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int N_CH        = 8,
  parameter int CONVST_CYC  = 4,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 2,
  parameter int SER_DIV     = 4,
  parameter int EOC_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              eoc_n,
  input  logic [DATA_W-1:0] db_in,
  output logic              convst_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              timeout
);
  localparam int FL    = frame_len(DATA_W, N_CH, TAG_EN);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(CONVST_CYC + EOC_TIMEOUT + RD_LOW_CYC + RD_HIGH_CYC + 1);
  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic                          overrun_q, overrun_d, timeout_q, timeout_d;
  logic [N_CH-1:0][DATA_W-1:0]   chbuf_q;
  logic [2:0]                    eoc_q;
  logic [FL-1:0]                 frame;
  logic                          eoc_fall, cap, load, ser_last;
  // eoc_q[1:0] is the synchroniser, eoc_q[2] the previous synchronised value
  assign eoc_fall = eoc_q[2] & ~eoc_q[1];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      eoc_q     <= '1;
      chbuf_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      eoc_q     <= {eoc_q[1:0], eoc_n};
      if (cap) chbuf_q[ch_q] <= db_in;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    ch_d      = ch_q;
    cap       = 1'b0;
    load      = 1'b0;
    overrun_d = overrun_q | (start & (state_q != S_IDLE));
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d   = S_CONVST;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_CONVST: if (cnt_q == CNT_W'(CONVST_CYC - 1)) begin
        state_d = S_WAIT_EOC;
        cnt_d   = '0;
      end
      S_WAIT_EOC: if (eoc_fall) begin
        state_d = S_RD_LOW;
        cnt_d   = '0;
        ch_d    = '0;
      end else if (cnt_q == CNT_W'(EOC_TIMEOUT - 1)) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end
      S_RD_LOW: if (cnt_q == CNT_W'(RD_LOW_CYC - 1)) begin
        cap     = 1'b1;
        state_d = S_RD_HIGH;
        cnt_d   = '0;
      end
      S_RD_HIGH: if (cnt_q == CNT_W'(RD_HIGH_CYC - 1)) begin
        cnt_d = '0;
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_SHIFT;
          load    = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_RD_LOW;
        end
      end
      S_SHIFT: if (ser_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // buf[0] lands in the frame MSBs so it is transmitted first
  for (genvar i = 0; i < N_CH; i++) begin : g_frame
`ifdef MAX11046_CH_TAG_EN
    localparam int TW = tag_w(N_CH);
    assign frame[FL-1-i*(DATA_W+TW) -: DATA_W+TW] = {TW'(i), chbuf_q[i]};
`else
    assign frame[FL-1-i*DATA_W -: DATA_W] = chbuf_q[i];
`endif
  end
  adc_frame_serializer #(.FL(FL), .SER_DIV(SER_DIV)) u_ser (
    .clk        (clock),
    .rst_n      (reset_n),
    .load_i     (load),
    .frame_i    (frame),
    .ser_clk_o  (ser_clk),
    .ser_data_o (ser_data),
    .ser_frame_o(ser_frame),
    .last_o     (ser_last)
  );
  assign convst_n = state_q != S_CONVST;
  assign cs_n     = !(state_q == S_RD_LOW || state_q == S_RD_HIGH);
  assign rd_n     = state_q != S_RD_LOW;
  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_max11046_burst_reader.sv
// tb_max11046_burst_reader: directed bench over three reader configurations.
module tb_max11046_burst_reader;
`ifdef MAX11046_CH_TAG_EN
  localparam int TAGON = 1;
`else
  localparam int TAGON = 0;
`endif
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;
  logic start [3];
  logic eoc_n [3];
  logic [15:0] db [3] = '{default: 16'h0};
  logic convst_n [3], cs_n [3], rd_n [3], ser_clk [3], ser_data [3], ser_frame [3];
  logic busy [3], done [3], overrun [3], timeout [3];
  logic [15:0] pat [3][8];
  int tests, fails;
  int rdp [3], rdbad [3], rdlen [3], rxn [3], dones [3], unstable [3], gap [3], fall_t [3];
  int cyc = 0;
  logic [255:0] rx [3];
  logic rd_p [3] = '{default: 1'b1};
  logic sck_p [3] = '{default: 1'b0};
  logic sd_p [3] = '{default: 1'b0};
  logic fr_p [3] = '{default: 1'b0};
  logic fseen [3];
  max11046_burst_reader #(.EOC_TIMEOUT(64)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .eoc_n(eoc_n[0]), .db_in(db[0]),
    .convst_n(convst_n[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .ser_clk(ser_clk[0]),
    .ser_data(ser_data[0]), .ser_frame(ser_frame[0]), .busy(busy[0]), .done(done[0]),
    .overrun(overrun[0]), .timeout(timeout[0]));
  max11046_burst_reader #(.N_CH(2), .EOC_TIMEOUT(64)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .eoc_n(eoc_n[1]), .db_in(db[1]),
    .convst_n(convst_n[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .ser_clk(ser_clk[1]),
    .ser_data(ser_data[1]), .ser_frame(ser_frame[1]), .busy(busy[1]), .done(done[1]),
    .overrun(overrun[1]), .timeout(timeout[1]));
  max11046_burst_reader #(.N_CH(1), .CONVST_CYC(1), .RD_LOW_CYC(1), .RD_HIGH_CYC(1),
                          .SER_DIV(1), .EOC_TIMEOUT(64)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .start(start[2]), .eoc_n(eoc_n[2]), .db_in(db[2]),
    .convst_n(convst_n[2]), .cs_n(cs_n[2]), .rd_n(rd_n[2]), .ser_clk(ser_clk[2]),
    .ser_data(ser_data[2]), .ser_frame(ser_frame[2]), .busy(busy[2]), .done(done[2]),
    .overrun(overrun[2]), .timeout(timeout[2]));
  function automatic int nch(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 1;
  endfunction
  function automatic int tw(input int k);
    return (k == 0) ? 3 : 1;
  endfunction
  function automatic int fl(input int k);
    return nch(k) * (16 + TAGON * tw(k));
  endfunction
  function automatic int rdl(input int k);
    return (k == 2) ? 1 : 3;
  endfunction
  function automatic logic [255:0] exp_frame(input int k);
    logic [255:0] f;
    f = '0;
    for (int c = 0; c < nch(k); c++) begin
      if (TAGON != 0) for (int b = tw(k) - 1; b >= 0; b--) f = {f[254:0], c[b]};
      for (int b = 15; b >= 0; b--) f = {f[254:0], pat[k][c][b]};
    end
    return f;
  endfunction
  // ADC data model plus serial-link receiver, sampled on the falling clock edge
  always @(negedge clock) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n || (start[k] && !busy[k])) begin
        rdp[k] = 0; rdbad[k] = 0; rdlen[k] = 0; rxn[k] = 0; rx[k] = '0;
        dones[k] = 0; unstable[k] = 0; gap[k] = -1; fseen[k] = 1'b0;
      end
      if (!rd_n[k]) begin
        if (rd_p[k]) begin
          rdp[k]++;
          rdlen[k] = 0;
          db[k] = pat[k][(rdp[k] - 1) % 8];
        end
        rdlen[k]++;
      end else if (!rd_p[k] && rdlen[k] != rdl(k)) rdbad[k]++;
      if (ser_clk[k] && !sck_p[k] && ser_frame[k]) begin
        rx[k] = {rx[k][254:0], ser_data[k]};
        rxn[k]++;
      end
      if (ser_data[k] !== sd_p[k] && !(sck_p[k] && !ser_clk[k]) && !(ser_frame[k] && !fr_p[k]))
        unstable[k]++;
      if (sck_p[k] && !ser_clk[k]) fall_t[k] = cyc;
      if (done[k]) begin
        dones[k]++;
        gap[k] = cyc - fall_t[k];
      end
      if (ser_frame[k]) fseen[k] = 1'b1;
      rd_p[k] = rd_n[k]; sck_p[k] = ser_clk[k]; sd_p[k] = ser_data[k]; fr_p[k] = ser_frame[k];
    end
  end
  task automatic pulse_start(input int k);
    @(posedge clock); #1 start[k] = 1'b1;
    @(posedge clock); #1 start[k] = 1'b0;
  endtask
  task automatic launch(input int k, input int dly, output bit ok);
    ok = 1'b0;
    pulse_start(k);
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clock); #1 ok = convst_n[k]; end
    if (ok) begin
      repeat (dly) @(posedge clock);
      #1 eoc_n[k] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); #1 ok = !cs_n[k]; end
    end
    eoc_n[k] = 1'b1;
  endtask
  task automatic wait_idle(input int k, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin @(negedge clock); #1 ok = !busy[k]; end
  endtask
  task automatic test_reset();
    logic [9:0] v;
    for (int k = 0; k < 3; k++) begin
      v = {convst_n[k], cs_n[k], rd_n[k], ser_clk[k], ser_data[k], ser_frame[k],
           busy[k], done[k], overrun[k], timeout[k]};
      tests++;
      if (v !== 10'b1110000000) begin fails++; $display("FAIL reset_outputs[%0d]: got %b expected 1110000000", k, v); end
    end
  endtask
  task automatic test_nominal();
    bit ok;
    launch(0, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL nominal_launch: got no EOC/cs_n response expected read start"); end
    wait_idle(0, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL nominal_idle: got busy expected idle"); end
    tests++; if (rdp[0] !== 8) begin fails++; $display("FAIL nominal_rd_count: got %0d expected 8", rdp[0]); end
    tests++; if (rdbad[0] !== 0) begin fails++; $display("FAIL nominal_rd_width: got %0d bad pulses expected 0", rdbad[0]); end
    tests++; if (rxn[0] !== fl(0)) begin fails++; $display("FAIL nominal_len: got %0d expected %0d", rxn[0], fl(0)); end
    tests++; if (rx[0] !== exp_frame(0)) begin fails++; $display("FAIL nominal_frame: got %h expected %h", rx[0], exp_frame(0)); end
    tests++; if (dones[0] !== 1) begin fails++; $display("FAIL nominal_done: got %0d expected 1", dones[0]); end
    tests++; if (gap[0] !== 1) begin fails++; $display("FAIL nominal_done_gap: got %0d expected 1", gap[0]); end
    tests++; if ({overrun[0], timeout[0]} !== 2'b00) begin fails++; $display("FAIL nominal_flags: got %b expected 00", {overrun[0], timeout[0]}); end
  endtask
  task automatic test_timeout();
    bit ok;
    int n;
    ok = 1'b0;
    pulse_start(0);
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clock); #1 ok = convst_n[0]; end
    for (n = 1; n <= 200; n++) begin @(negedge clock); #1 if (timeout[0]) break; end
    tests++; if (n !== 64) begin fails++; $display("FAIL timeout_cycle: got %0d expected 64", n); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy[0]); end
    tests++; if (rdp[0] !== 0) begin fails++; $display("FAIL timeout_rd: got %0d expected 0", rdp[0]); end
    tests++; if ({fseen[0], dones[0] != 0} !== 2'b00) begin fails++; $display("FAIL timeout_frame_done: got %b%0d expected frame 0 done 0", fseen[0], dones[0]); end
  endtask
  task automatic test_overrun();
    bit ok;
    launch(0, 5, ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clock); #1 ok = ser_frame[0]; end
    tests++; if (!ok) begin fails++; $display("FAIL overrun_shift: got no frame expected SHIFT"); end
    pulse_start(0);
    tests++; if ({overrun[0], busy[0]} !== 2'b11) begin fails++; $display("FAIL overrun_set: got %b expected 11", {overrun[0], busy[0]}); end
    wait_idle(0, 3000, ok);
    tests++; if (rx[0] !== exp_frame(0) || dones[0] !== 1) begin fails++; $display("FAIL overrun_frame: got %h/%0d expected %h/1", rx[0], dones[0], exp_frame(0)); end
    tests++; if (overrun[0] !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun[0]); end
    launch(0, 5, ok);
    tests++; if (overrun[0] !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b expected 0", overrun[0]); end
    wait_idle(0, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL overrun_idle: got busy expected idle"); end
  endtask
  task automatic test_reset_mid();
    bit ok;
    launch(0, 8, ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); #1 ok = rdp[0] == 4 && !rd_n[0]; end
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_reach: got %0d reads expected 4th RD_LOW", rdp[0]); end
    reset_n = 1'b0;
    #1;
    tests++; if ({cs_n[0], rd_n[0], busy[0], convst_n[0], ser_frame[0]} !== 5'b11010) begin
      fails++; $display("FAIL rstmid_async: got %b expected 11010", {cs_n[0], rd_n[0], busy[0], convst_n[0], ser_frame[0]}); end
    #10 reset_n = 1'b1;
    launch(0, 12, ok);
    wait_idle(0, 3000, ok);
    tests++; if (rdp[0] !== 8 || rx[0] !== exp_frame(0) || dones[0] !== 1) begin
      fails++; $display("FAIL rstmid_rerun: got reads %0d frame %h done %0d expected 8 %h 1", rdp[0], rx[0], dones[0], exp_frame(0)); end
  endtask
  task automatic test_two_ch();
    bit ok;
    launch(1, 10, ok);
    wait_idle(1, 2000, ok);
    tests++; if (rxn[1] !== fl(1)) begin fails++; $display("FAIL twoch_len: got %0d expected %0d", rxn[1], fl(1)); end
    tests++; if (rx[1] !== exp_frame(1)) begin fails++; $display("FAIL twoch_frame: got %h expected %h", rx[1], exp_frame(1)); end
    tests++; if (unstable[1] !== 0) begin fails++; $display("FAIL twoch_stable: got %0d changes expected 0", unstable[1]); end
    tests++; if (dones[1] !== 1) begin fails++; $display("FAIL twoch_done: got %0d expected 1", dones[1]); end
  endtask
  task automatic test_min();
    bit ok;
    launch(2, 3, ok);
    wait_idle(2, 500, ok);
    tests++; if (rdp[2] !== 1 || rdbad[2] !== 0) begin fails++; $display("FAIL min_read: got %0d reads %0d bad expected 1 0", rdp[2], rdbad[2]); end
    tests++; if (rxn[2] !== fl(2) || rx[2] !== exp_frame(2)) begin fails++; $display("FAIL min_frame: got %0d %h expected %0d %h", rxn[2], rx[2], fl(2), exp_frame(2)); end
    tests++; if (gap[2] !== 1 || dones[2] !== 1) begin fails++; $display("FAIL min_done: got gap %0d count %0d expected 1 1", gap[2], dones[2]); end
    tests++; if (unstable[2] !== 0) begin fails++; $display("FAIL min_stable: got %0d expected 0", unstable[2]); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin start[k] = 1'b0; eoc_n[k] = 1'b1; end
    pat[0] = '{16'hA5A5, 16'h0001, 16'h0003, 16'h0F0F, 16'h1234, 16'h7FFE, 16'hFFFF, 16'h8000};
    pat[1] = '{16'h1234, 16'hFEDC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    pat[2] = '{16'hC3A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #1;
    test_reset();
    test_nominal();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_two_ch();
    test_min();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
